celda_serie_izqder: RTL and testbench

Bit-serial, left-to-right evaluator of the iterative cell chain that feeds `celda_final`. It loads an N-bit word and scans it one bit per clock, MSB first. Each clock applies the intermediate-cell rule: detect at least one pair of adjacent 1s. When the scan finishes, it presents the accumulated result on `f_mid` for the downstream `celda_final` stage. It replaces the N-cell combinational chain with one cell plus a state machine, a counter and a start/done handshake.

---
 rtl/celda_serie_izqder_if.sv | 21 ++
 rtl/celda_serie_izqder.sv | 97 +++++++++
 tb/tb_celda_serie_izqder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/celda_serie_izqder_if.sv
// Start/done handshake bundle between a requester and the serial pair-detector cell.
interface celda_serie_izqder_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] data_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic         f_mid;

    modport master (
        output start, data_in,
        input  ready, busy, done, f_mid
    );

    modport slave (
        input  start, data_in,
        output ready, busy, done, f_mid
    );
endinterface

// File: rtl/celda_serie_izqder.sv
// Bit-serial MSB-first scan that flags any pair of adjacent 1s in an N-bit word.
// Optional build macro CELDA_SERIE_EARLY_EXIT_EN ends the scan as soon as a pair is seen.
module celda_serie_izqder #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    celda_serie_izqder_if.slave   bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sh_q, sh_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           prev_q, prev_d;
    logic           found_q, found_d;
    logic           f_mid_q, f_mid_d;
    logic           bit_cur;
    logic           found_upd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            found_q <= 1'b0;
            f_mid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            found_q <= found_d;
            f_mid_q <= f_mid_d;
        end
    end

    // One intermediate cell: the current bit plus the previous one detects a pair.
    assign bit_cur   = sh_q[N-1];
    assign found_upd = found_q | (prev_q & bit_cur);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        found_d = found_q;
        f_mid_d = f_mid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_d    = bus.data_in;
                    cnt_d   = CW'(N);
                    prev_d  = 1'b0;
                    found_d = 1'b0;
                    f_mid_d = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                found_d = found_upd;
                prev_d  = bit_cur;
                sh_d    = {sh_q[N-2:0], 1'b0};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    f_mid_d = found_upd;
                    state_d = DONE;
                end
`ifdef CELDA_SERIE_EARLY_EXIT_EN
                else if (found_upd) begin
                    f_mid_d = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q == SCAN);
    assign bus.done  = (state_q == DONE);
    assign bus.f_mid = f_mid_q;
endmodule

// File: tb/tb_celda_serie_izqder.sv
// Scoreboard bench: stimulus pushes expected result/latency, a negedge monitor pops on done.
module tb_celda_serie_izqder;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [N-1:0] d;
        bit           f;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   busy_run = 0;
    bit   last_f = 1'b0;
    bit   prev_hold = 1'b0;
    int   prev_acc = 0;
    int   prev_lat = 0;

    celda_serie_izqder_if #(.N(N)) bus ();

    celda_serie_izqder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: result is "any adjacent 1s"; early-exit latency is the MSB-based
    // 1-based position of the second bit of the first such pair.
    function automatic void model(input logic [N-1:0] d, output bit f, output int lat);
        logic [N-1:0] pairs;
        pairs = d & (d >> 1);
        f     = (pairs != '0);
        lat   = N;
`ifdef CELDA_SERIE_EARLY_EXIT_EN
        for (int p = N; p >= 2; p--) begin
            if (d[N-p+1] && d[N-p]) lat = p;
        end
`endif
    endfunction

    task automatic send(input logic [N-1:0] d, input bit hold);
        exp_t e;
        int   guard;
        bus.start   = 1'b1;
        bus.data_in = d;
        guard = 0;
        while (!bus.ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            chk("ready_timeout", 0, 1);
        end else begin
            @(posedge clk); #1;
            e.d   = d;
            e.acc = cyc;
            model(d, e.f, e.lat);
            sb.push_back(e);
            chk("fmid_clear_at_accept", int'(bus.f_mid), 0);
            if (prev_hold) chk("b2b_spacing", e.acc - prev_acc, prev_lat + 2);
            prev_hold = hold;
            prev_acc  = e.acc;
            prev_lat  = e.lat;
        end
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || !bus.ready) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) chk("drain_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_fmid"},  int'(bus.f_mid), 0);
        chk({nm, "_done"},  int'(bus.done),  0);
        chk({nm, "_busy"},  int'(bus.busy),  0);
        chk({nm, "_ready"}, int'(bus.ready), 1);
    endtask

    task automatic async_reset(input string nm);
        #2 rst = 1'b1;
        #1 check_reset_outputs(nm);
        sb.delete();
        prev_hold = 1'b0;
        @(posedge clk); #3 rst = 1'b0;
    endtask

    // Monitor: one-hot state outputs, f_mid low while scanning, f_mid held in IDLE.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
            last_f   = 1'b0;
        end else begin
            chk("onehot", int'(bus.ready) + int'(bus.busy) + int'(bus.done), 1);
            if (bus.busy) begin
                busy_run++;
                chk("fmid_low_in_scan", int'(bus.f_mid), 0);
            end
            if (bus.ready) chk("fmid_hold_idle", int'(bus.f_mid), int'(last_f));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("fmid", int'(bus.f_mid), int'(e.f));
                    chk("latency", cyc - e.acc, e.lat);
                    chk("busy_cycles", busy_run, e.lat);
                    $display("txn data=%b f_mid=%0d exp=%0d lat=%0d", e.d, bus.f_mid, e.f, cyc - e.acc);
                end
                last_f   = bus.f_mid;
                busy_run = 0;
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        bus.start   = 1'b0;
        bus.data_in = '0;
        #2 check_reset_outputs("rst_init");
        #20 rst = 1'b0;
        @(posedge clk); #1;

        send(8'b1010_1010, 1'b0); drain();
        send(8'b0000_0011, 1'b0); drain();
        send(8'b1100_0000, 1'b0); drain();

        // start pulsed during SCAN must be ignored
        send(8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b1; bus.data_in = 8'h00;
        @(posedge clk); #1 bus.start = 1'b0;
        drain();
        send(8'h00, 1'b0); drain();

        // start held high across three words
        send(8'h81, 1'b1);
        send(8'h18, 1'b1);
        send(8'h01, 1'b0);
        drain();

        // reset mid-scan: abort, no done
        send(8'hFF, 1'b0);
        repeat (2) @(posedge clk);
        async_reset("rst_scan");
        repeat (N + 4) @(posedge clk);
        #1 chk("no_done_after_abort_ready", int'(bus.ready), 1);

        // reset in IDLE while f_mid=1
        send(8'h03, 1'b0); drain();
        @(posedge clk);
        async_reset("rst_idle");

        for (int i = 0; i < 40; i++) begin
            r = N'($urandom);
            send(r, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) drain();
        end
        bus.start = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
